// File: rtl/generador_obstaculo.sv
// Falling-obstacle generator: spawns in a pseudo-random lane, descends one STEP per tick,
// scores each obstacle that leaves the screen and latches a crash on the collision flag.
`timescale 1ns/1ps
module generador_obstaculo #(
   parameter int TICK_DIV = 833333,
   parameter int STEP     = 2,
   parameter int Y_START  = 0,
   parameter int Y_END    = 480,
   parameter int LEFT_X   = 250,
   parameter int RIGHT_X  = 350
) (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic       iStart,
   input  logic       iStop,
   output logic [9:0] oPosicionXT,
   output logic [8:0] oPosicionYT,
   output logic       oActivo,
   output logic       oCrash,
   output logic [7:0] oPuntos
);

   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, SPAWN, MOVE, CRASH} state_t;

   state_t           r_state;
   logic [7:0]       r_lfsr;
   logic [CNT_W-1:0] r_cnt;

   logic       w_tick;
   logic       w_fb;
   logic [9:0] w_next;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // x^8+x^6+x^5+x^4+1, shifted left with feedback into bit 0
   assign w_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
   assign w_tick = (r_state == MOVE) && (r_cnt == CNT_MAX);
   assign w_next = {1'b0, oPosicionYT} + 10'(STEP);

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_state     <= IDLE;
         r_lfsr      <= 8'hA5;
         r_cnt       <= '0;
         oPosicionXT <= 10'(LEFT_X);
         oPosicionYT <= 9'(Y_START);
         oActivo     <= 1'b0;
         oCrash      <= 1'b0;
         oPuntos     <= 8'd0;
      end else begin
         r_lfsr <= {r_lfsr[6:0], w_fb};
         r_cnt  <= '0;
         case (r_state)
            IDLE: begin
               if (iStart) r_state <= SPAWN;
            end
            SPAWN: begin
               oPosicionYT <= 9'(Y_START);
               oPosicionXT <= r_lfsr[0] ? 10'(RIGHT_X) : 10'(LEFT_X);
               oActivo     <= 1'b1;
               r_state     <= MOVE;
            end
            MOVE: begin
               // collision wins over a coincident tick: nothing moves, nothing scores
               if (iStop) begin
                  oCrash  <= 1'b1;
                  oActivo <= 1'b0;
                  r_state <= CRASH;
               end else if (w_tick) begin
                  if (w_next < 10'(Y_END)) begin
                     oPosicionYT <= w_next[8:0];
                  end else begin
                     oPuntos <= sat_inc(oPuntos);
                     oActivo <= 1'b0;
                     r_state <= SPAWN;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            CRASH: begin
               if (iStart) begin
                  oCrash  <= 1'b0;
                  oPuntos <= 8'd0;
                  r_state <= SPAWN;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_generador_obstaculo.sv
// Directed bench for generador_obstaculo with TICK_DIV=4, STEP=8 and default geometry.
`timescale 1ns/1ps
module tb_generador_obstaculo;

   logic       iClk;
   logic       iRst_n;
   logic       iStart;
   logic       iStop;
   logic [9:0] oPosicionXT;
   logic [8:0] oPosicionYT;
   logic       oActivo;
   logic       oCrash;
   logic [7:0] oPuntos;

   int   checks = 0;
   int   errors = 0;
   int   exp_x  = 0;
   logic [7:0] m_lfsr;

   generador_obstaculo #(
      .TICK_DIV(4),
      .STEP    (8)
   ) dut (
      .iClk       (iClk),
      .iRst_n     (iRst_n),
      .iStart     (iStart),
      .iStop      (iStop),
      .oPosicionXT(oPosicionXT),
      .oPosicionYT(oPosicionYT),
      .oActivo    (oActivo),
      .oCrash     (oCrash),
      .oPuntos    (oPuntos)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   // Reference lane selector: 8-bit LFSR, seed A5, taps 8,6,5,4
   always @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) m_lfsr <= 8'hA5;
      else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   task automatic step(input int n);
      repeat (n) @(posedge iClk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_x"},     32'(oPosicionXT), 32'd250);
      check({tag, "_y"},     32'(oPosicionYT), 32'd0);
      check({tag, "_act"},   32'(oActivo),     32'd0);
      check({tag, "_crash"}, 32'(oCrash),      32'd0);
      check({tag, "_pts"},   32'(oPuntos),     32'd0);
   endtask

   initial begin
      iRst_n = 1'b0;
      iStart = 1'b0;
      iStop  = 1'b0;
      step(1);
      check_reset_vals("rst");
      iRst_n = 1'b1;
      step(2);
      check("idle_act", 32'(oActivo), 32'd0);
      check("idle_y",   32'(oPosicionYT), 32'd0);
      iStop = 1'b1;
      step(1);
      iStop = 1'b0;
      check("idle_stop_crash", 32'(oCrash), 32'd0);

      // start -> SPAWN -> MOVE
      iStart = 1'b1;
      step(1);
      iStart = 1'b0;
      exp_x = m_lfsr[0] ? 350 : 250;
      check("spawn_act", 32'(oActivo), 32'd0);
      step(1);
      check("move_act", 32'(oActivo), 32'd1);
      check("move_y0",  32'(oPosicionYT), 32'd0);
      check("move_x",   32'(oPosicionXT), 32'(exp_x));
      step(2);
      iStart = 1'b1;
      step(1);
      iStart = 1'b0;
      check("pre_tick_y",   32'(oPosicionYT), 32'd0);
      check("start_in_move", 32'(oActivo), 32'd1);
      step(1);
      check("first_tick_y", 32'(oPosicionYT), 32'd8);

      // full descent
      for (int k = 2; k <= 59; k++) begin
         step(4);
         check("descent_y", 32'(oPosicionYT), 32'(8 * k));
      end
      step(4);
      check("clear_act", 32'(oActivo), 32'd0);
      check("clear_pts", 32'(oPuntos), 32'd1);
      check("clear_y",   32'(oPosicionYT), 32'd472);
      exp_x = m_lfsr[0] ? 350 : 250;
      step(1);
      check("respawn_y",   32'(oPosicionYT), 32'd0);
      check("respawn_x",   32'(oPosicionXT), 32'(exp_x));
      check("respawn_act", 32'(oActivo), 32'd1);

      // crash at Y=200
      step(100);
      check("pre_crash_y", 32'(oPosicionYT), 32'd200);
      iStop = 1'b1;
      step(1);
      iStop = 1'b0;
      check("crash_flag", 32'(oCrash), 32'd1);
      check("crash_act",  32'(oActivo), 32'd0);
      check("crash_y",    32'(oPosicionYT), 32'd200);
      step(100);
      check("frozen_y",     32'(oPosicionYT), 32'd200);
      check("frozen_x",     32'(oPosicionXT), 32'(exp_x));
      check("frozen_crash", 32'(oCrash), 32'd1);
      check("frozen_pts",   32'(oPuntos), 32'd1);

      // restart from CRASH
      iStart = 1'b1;
      step(1);
      iStart = 1'b0;
      check("restart_crash", 32'(oCrash), 32'd0);
      check("restart_pts",   32'(oPuntos), 32'd0);
      check("restart_act",   32'(oActivo), 32'd0);
      exp_x = m_lfsr[0] ? 350 : 250;
      step(1);
      check("restart_y", 32'(oPosicionYT), 32'd0);
      check("restart_x", 32'(oPosicionXT), 32'(exp_x));

      // stop coincident with first tick
      step(3);
      iStop = 1'b1;
      step(1);
      iStop = 1'b0;
      check("stop_tick_y",     32'(oPosicionYT), 32'd0);
      check("stop_tick_crash", 32'(oCrash), 32'd1);

      // stop coincident with the clearing tick
      iStart = 1'b1;
      step(1);
      iStart = 1'b0;
      step(1);
      step(236);
      check("edge_y", 32'(oPosicionYT), 32'd472);
      step(3);
      iStop = 1'b1;
      step(1);
      iStop = 1'b0;
      check("stop_clear_y",     32'(oPosicionYT), 32'd472);
      check("stop_clear_pts",   32'(oPuntos), 32'd0);
      check("stop_clear_crash", 32'(oCrash), 32'd1);
      check("stop_clear_act",   32'(oActivo), 32'd0);

      // score saturation
      iStart = 1'b1;
      step(1);
      iStart = 1'b0;
      step(1);
      for (int i = 1; i <= 256; i++) begin
         step(240);
         check("sat_spawn_act", 32'(oActivo), 32'd0);
         check("sat_pts", 32'(oPuntos), 32'((i > 255) ? 255 : i));
         step(1);
      end

      // asynchronous reset mid-MOVE
      step(68);
      check("pre_rst_y", 32'(oPosicionYT), 32'd136);
      #3;
      iRst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      #2;
      iRst_n = 1'b1;
      step(3);
      check("post_rst_act", 32'(oActivo), 32'd0);
      check("post_rst_y",   32'(oPosicionYT), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
